// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants, state encoding and request type for the SRAM controller
package sram_pkg;
    localparam int ADDR_W = 14;
    localparam int BYTES  = 4;
    localparam int BYTE_W = 8;
    localparam int DATA_W = BYTES * BYTE_W;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BYTES-1:0]  wstrb;
    } req_t;

    // Active-low byte enables for an accepted request; reads leave every byte untouched.
    function automatic logic [BYTES-1:0] web_for(input req_t r);
        return r.write ? ~r.wstrb : {BYTES{1'b1}};
    endfunction
endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - synchronous first-word-fall-through FIFO holding read responses
module sram_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_pop   = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - valid/ready front end driving a byte-writable single-port SRAM macro
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int WORDS          = 16384,
    parameter int RSP_DEPTH      = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              clear_done,
    output logic              sram_cs,
    output logic [3:0]        sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [31:0]       sram_di,
    output logic              sram_oe,
    input  logic [31:0]       sram_do
);
    localparam int PKG_AW = sram_pkg::ADDR_W;
    localparam int CW     = $clog2(RSP_DEPTH + 1);
    localparam int CW1    = CW + 1;

    localparam logic [0:0]        ST_CLEAR  = 1'(CLEAR);
    localparam logic [0:0]        ST_RUN    = 1'(RUN);
    localparam logic [0:0]        ST_INIT   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_clear_done;
    logic              r_rd_pending;

    req_t              w_req;
    logic              w_accept;
    logic              w_pop;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [CW-1:0]     w_fifo_count;
    logic [CW1-1:0]    w_inflight;

    assign w_req = '{write: req_write, addr: PKG_AW'(req_addr), wdata: req_wdata, wstrb: req_wstrb};

    // Credit counts the read already in the SRAM pipe so its response always has a FIFO slot.
    assign w_inflight = CW1'(w_fifo_count) + CW1'(r_rd_pending);
    assign req_ready  = ~RST & (r_state == ST_RUN) & ~w_fifo_full
                      & (w_inflight < CW1'(RSP_DEPTH));
    assign w_accept   = req_valid & req_ready;

    assign clear_done = r_clear_done;
    assign sram_oe    = r_rd_pending;
    assign w_pop      = rsp_valid & rsp_ready;
    assign rsp_valid  = ~w_fifo_empty;

    always_comb begin
        sram_cs  = 1'b0;
        sram_web = 4'b1111;
        sram_a   = ADDR_W'(w_req.addr);
        sram_di  = w_req.wdata;
        if (r_state == ST_CLEAR) begin
            sram_cs  = ~RST;
            sram_web = RST ? 4'b1111 : 4'b0000;
            sram_a   = r_clr_cnt;
            sram_di  = '0;
        end else if (w_accept) begin
            sram_cs  = 1'b1;
            sram_web = web_for(w_req);
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state      <= ST_INIT;
            r_clr_cnt    <= '0;
            r_clear_done <= (CLEAR_ON_RESET == 0);
            r_rd_pending <= 1'b0;
        end else begin
            r_rd_pending <= w_accept & ~w_req.write;
            if (r_state == ST_CLEAR) begin
                if (r_clr_cnt == LAST_ADDR) begin
                    r_state      <= ST_RUN;
                    r_clear_done <= 1'b1;
                end else begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
            end
        end
    end

    sram_rsp_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk   (CK),
        .i_rst   (RST),
        .i_push  (r_rd_pending),
        .i_wdata (sram_do),
        .i_pop   (w_pop),
        .o_rdata (rsp_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );
endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - randomized self-checking bench for sram_ctrl with a reference memory model
module tb_sram_ctrl;
    localparam int AW    = 14;
    localparam int WORDS = 16;
    localparam int DEPTH = 4;

    logic          CK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          clear_done;
    logic          sram_cs;
    logic [3:0]    sram_web;
    logic [AW-1:0] sram_a;
    logic [31:0]   sram_di;
    logic          sram_oe;
    logic [31:0]   sram_do;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;
    int cyc      = 0;
    bit in_run   = 0;

    logic [31:0] sram_mem [0:(1<<AW)-1];
    logic [31:0] do_q = '0;
    logic [31:0] exp_mem [int];
    logic [31:0] exp_q [$];
    logic [31:0] pop_data [$];
    int          pop_cyc [$];
    logic [31:0] m_word;
    logic [3:0]  m_web;

    always #5 CK = ~CK;

    sram_ctrl #(
        .ADDR_W         (AW),
        .WORDS          (WORDS),
        .RSP_DEPTH      (DEPTH),
        .CLEAR_ON_RESET (1)
    ) dut (
        .CK         (CK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .clear_done (clear_done),
        .sram_cs    (sram_cs),
        .sram_web   (sram_web),
        .sram_a     (sram_a),
        .sram_di    (sram_di),
        .sram_oe    (sram_oe),
        .sram_do    (sram_do)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM macro: synchronous write per byte, registered read data
    initial for (int i = 0; i < (1 << AW); i++) sram_mem[i] = $urandom;
    always @(posedge CK) begin
        if (sram_cs) begin
            if (&sram_web) do_q <= sram_mem[sram_a];
            for (int b = 0; b < 4; b++)
                if (!sram_web[b]) sram_mem[sram_a][8*b +: 8] <= sram_di[8*b +: 8];
        end
    end
    assign sram_do = do_q;

    always @(posedge CK) cyc++;

    // Reference model: observe mid-cycle what the coming edge will accept/pop
    always @(negedge CK) begin
        if (!RST && in_run) begin
            if (req_valid && req_ready) begin
                acc_cnt++;
                chk("pin_cs", sram_cs, 1);
                chk("pin_a", sram_a, req_addr);
                if (req_write) begin
                    m_web = ~req_wstrb;
                    chk("pin_web_wr", sram_web, m_web);
                    chk("pin_di", sram_di, req_wdata);
                    m_word = exp_mem.exists(int'(req_addr)) ? exp_mem[int'(req_addr)] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (req_wstrb[b]) m_word[8*b +: 8] = req_wdata[8*b +: 8];
                    exp_mem[int'(req_addr)] = m_word;
                end else begin
                    chk("pin_web_rd", sram_web, 4'hf);
                    exp_q.push_back(exp_mem[int'(req_addr)]);
                end
            end else begin
                chk("pin_idle_cs", sram_cs, 0);
                chk("pin_idle_web", sram_web, 4'hf);
            end
            if (rsp_valid && rsp_ready) begin
                pop_data.push_back(rsp_rdata);
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_data", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int n);
        n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        @(negedge CK);
        while (!req_ready && n < 100) begin
            @(negedge CK);
            n++;
        end
        if (n >= 100) chk("send_timeout", 1, 0);
        @(posedge CK); #1;
    endtask

    task automatic reset_and_clear();
        RST = 1'b1;
        repeat (2) begin @(posedge CK); #1; end
        @(negedge CK);
        chk("rst_cs", sram_cs, 0);
        chk("rst_web", sram_web, 4'hf);
        chk("rst_oe", sram_oe, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge CK); #1;
        RST = 1'b0;
        for (int k = 0; k < WORDS; k++) begin
            @(negedge CK);
            chk("clr_cs", sram_cs, 1);
            chk("clr_web", sram_web, 4'h0);
            chk("clr_a", sram_a, AW'(k));
            chk("clr_di", sram_di, 0);
            chk("clr_ready", req_ready, 0);
            chk("clr_done_low", clear_done, 0);
        end
        @(negedge CK);
        chk("clr_done", clear_done, 1);
        chk("run_ready", req_ready, 1);
        for (int k = 0; k < WORDS; k++) exp_mem[k] = 32'h0;
        in_run = 1;
        @(posedge CK); #1;
    endtask

    task automatic read_lat(input logic [AW-1:0] a, input logic [31:0] exp);
        int n;
        rsp_ready = 1'b1;
        send(1'b0, a, 32'h0, 4'h0, n);
        req_valid = 1'b0;
        @(negedge CK);
        chk("lat_oe", sram_oe, 1);
        chk("lat_early", rsp_valid, 0);
        @(negedge CK);
        chk("lat_valid", rsp_valid, 1);
        chk("lat_data", rsp_rdata, exp);
        @(posedge CK); #1;
    endtask

    initial begin
        int n;
        int a0;
        int k;
        int last;

        reset_and_clear();

        read_lat(AW'(5), 32'h0);

        send(1'b1, AW'(16), 32'hDEADBEEF, 4'hf, n);
        send(1'b1, AW'(16), 32'h000000AA, 4'h1, n);
        read_lat(AW'(16), 32'hDEADBEAA);

        for (int i = 0; i < 8; i++) send(1'b1, AW'(i), 32'(i), 4'hf, n);
        rsp_ready = 1'b1;
        pop_data.delete();
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            send(1'b0, AW'(i), 32'h0, 4'h0, n);
            chk("b2b_ready", n, 0);
        end
        req_valid = 1'b0;
        repeat (4) begin @(posedge CK); #1; end
        chk("b2b_count", pop_data.size(), 8);
        for (int i = 0; i < pop_data.size(); i++) begin
            chk("b2b_data", pop_data[i], i);
            chk("b2b_consecutive", pop_cyc[i] - pop_cyc[0], i);
        end

        // Backpressure: credit stops acceptance at RSP_DEPTH outstanding reads
        rsp_ready = 1'b0;
        pop_data.delete();
        a0 = acc_cnt;
        k = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = '0;
        repeat (10) begin
            @(posedge CK); #1;
            if (acc_cnt - a0 != k) begin
                k = acc_cnt - a0;
                req_addr = AW'(k);
            end
        end
        req_valid = 1'b0;
        chk("bp_accepted", acc_cnt - a0, DEPTH);
        @(negedge CK);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        @(posedge CK); #1;
        rsp_ready = 1'b1;
        @(posedge CK); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = AW'(4);
        @(negedge CK);
        chk("pp_ready_reopen", req_ready, 1);
        @(posedge CK); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge CK);
        chk("pp_ready_full", req_ready, 0);
        @(posedge CK); #1;
        rsp_ready = 1'b0;
        @(negedge CK);
        chk("pp_count_kept", req_ready, 1);
        @(posedge CK); #1;
        rsp_ready = 1'b1;
        repeat (8) begin @(posedge CK); #1; end
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_pop_count", pop_data.size(), 5);
        for (int i = 0; i < pop_data.size(); i++) chk("bp_order", pop_data[i], i);
        @(negedge CK);
        chk("bp_ready_again", req_ready, 1);
        @(posedge CK); #1;

        last = acc_cnt;
        req_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req_valid || acc_cnt != last) begin
                last      = acc_cnt;
                req_valid = ($urandom_range(3) != 0);
                req_write = 1'($urandom_range(1));
                req_addr  = AW'($urandom_range(15));
                req_wdata = $urandom;
                req_wstrb = 4'($urandom);
            end
            rsp_ready = ($urandom_range(2) != 0);
            @(posedge CK); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) begin @(posedge CK); #1; end
        chk("rand_drained", exp_q.size(), 0);
        @(negedge CK);
        chk("rand_ready", req_ready, 1);
        @(posedge CK); #1;

        // Reset with two responses queued: they must vanish and the clear restarts
        rsp_ready = 1'b0;
        send(1'b0, AW'(1), 32'h0, 4'h0, n);
        send(1'b0, AW'(2), 32'h0, 4'h0, n);
        req_valid = 1'b0;
        @(posedge CK); #1;
        @(negedge CK);
        chk("rst_q_valid", rsp_valid, 1);
        @(posedge CK); #1;
        in_run = 0;
        RST = 1'b1;
        exp_q.delete();
        @(posedge CK); #1;
        @(negedge CK);
        chk("rst_flush_valid", rsp_valid, 0);
        chk("rst_flush_oe", sram_oe, 0);
        reset_and_clear();
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CK);
            chk("no_stale", rsp_valid, 0);
        end
        @(posedge CK); #1;
        read_lat(AW'(2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Initiator-side controller for the 16384×32 byte-writable single-port SRAM macro. It converts a valid/ready request channel into SRAM pin activity: chip select, per-byte write enables, address, write data and output enable. It returns read data on a valid/ready response channel that is buffered against backpressure. After reset it can optionally zero-fill the whole array. It sits between accelerator-side masters and the SRAM instance.

## Interface
Parameters:
- ADDR_W, 14, SRAM word-address width
- WORDS, 16384, words swept by the clear sequence
- RSP_DEPTH, 4, response FIFO entries (≥3 for full read throughput)
- CLEAR_ON_RESET, 1, 1 = zero-fill array after reset

Ports:
- CK  in  1  clock; one clock domain; reset is synchronous and active-high
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when valid&ready at a CK posedge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  32  write data
- req_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i]
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts read data
- rsp_rdata  out  32  read data
- clear_done  out  1  high once the clear sequence has finished (or immediately when CLEAR_ON_RESET=0)
- sram_cs  out  1  to SRAM CS
- sram_web  out  4  to SRAM WEB3..WEB0, active-low per byte
- sram_a  out  ADDR_W  to SRAM A
- sram_di  out  32  to SRAM DI
- sram_oe  out  1  to SRAM OE
- sram_do  in  32  from SRAM DO

## Operation
- FSM states: CLEAR and RUN. RST enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- CLEAR:
  - req_ready=0; clear counter runs 0..WORDS-1.
  - Each cycle drives sram_cs=1, sram_web=4'b0000, sram_a=counter, sram_di=0.
  - At counter=WORDS-1 the FSM moves to RUN and clear_done becomes 1 on the next cycle.
- RUN:
  - req_ready = (fifo_count + rd_pending) < RSP_DEPTH. This applies to reads and writes alike. It does not depend on rsp_ready.
  - SRAM pins are combinational from an accepted request: sram_cs = req_valid & req_ready.
  - Writes: sram_web = ~req_wstrb. A write with wstrb=0 still asserts CS and changes no memory.
  - Reads: sram_web = 4'b1111.
  - sram_a = req_addr and sram_di = req_wdata.
  - When CS is low, sram_web = 4'b1111; sram_a and sram_di hold don't-care values, and the bench must not check them.
  - Writes generate no response.
- rd_pending: registered flag, set the cycle after a read is accepted.
  - While rd_pending=1, sram_oe=1; otherwise sram_oe=0.
  - sram_do is pushed into the response FIFO at the end of that cycle.
- Response FIFO: first-word-fall-through.
  - rsp_valid = !empty; pop on rsp_valid & rsp_ready.
  - Push and pop may occur in the same cycle. The credit rule guarantees the FIFO never overflows.
- Responses return strictly in request order.
- Read-after-write to the same address is issued back to back with no hazard logic, because the SRAM write completes at the accept edge.

## Timing
- Reset values:
  - req_ready=0 in CLEAR, 1 in RUN.
  - rsp_valid=0, clear_done=0 (1 if CLEAR_ON_RESET=0).
  - sram_cs=0, sram_web=4'b1111, sram_oe=0.
  - FIFO empty, rd_pending=0, counter=0.
- Clear duration: WORDS cycles, from the first cycle after RST deasserts to the last zero write.
- Read latency: request accepted at edge N; DO is valid during cycle N+1 (OE high); rsp_valid rises after edge N+1. That is 2 edges from accept to rsp_valid.
- Throughput: one request per cycle sustained when RSP_DEPTH≥3 and rsp_ready=1.
- RST asserted mid-clear or mid-traffic:
  - The next edge flushes the FIFO, drops rd_pending and restarts the clear from 0.
  - Pending responses are lost.

## Structure
- Package sram_pkg holds:
  - ADDR_W=14, DATA_W=32, BYTES=4, BYTE_W=8.
  - typedef enum {CLEAR, RUN} ctrl_state_e.
  - typedef struct req_t {write, addr, wdata, wstrb}.
- Sub-module sram_rsp_fifo: a parameterized synchronous FWFT FIFO (width DATA_W, depth RSP_DEPTH) with push, pop, count, empty and full.
- The top level instantiates it together with the FSM, the clear counter and the pin drive.

## Test plan
- Reset with CLEAR_ON_RESET=1, WORDS=16:
  - 16 cycles of cs=1, web=0000, a=0..15, di=0; then clear_done=1 and req_ready=1.
  - A read of address 5 returns 0x00000000.
- Write 0xDEADBEEF to addr 0x0010 with wstrb=1111, then write 0x000000AA with wstrb=0001, then read 0x0010:
  - rsp_rdata=0xDEADBEAA.
  - rsp_valid rises 2 edges after the read is accepted.
- 8 back-to-back reads of addr 0..7 (preloaded with value = addr) with rsp_ready=1:
  - req_ready stays 1.
  - Responses 0..7 arrive in order on 8 consecutive cycles.
- rsp_ready=0 while issuing reads:
  - Exactly RSP_DEPTH reads are accepted, then req_ready=0.
  - Raising rsp_ready drains in order and re-opens req_ready.
- Simultaneous push and pop with the FIFO at RSP_DEPTH-1 entries: no overflow, no data lost, count unchanged.
- RST asserted mid-stream with 2 responses queued:
  - rsp_valid=0 on the next cycle and the clear restarts at address 0.
  - No stale data appears afterwards.
